// File: rtl/sm_divider_if.sv
// Host-side handshake and operand/result bundle for the sequential divider.
// The host drives start/operands (master); the divider returns results and status (slave).
interface sm_divider_if #(
    parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             done;
  logic             busy;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, done, busy, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, done, busy, div_by_zero
  );
endinterface

// File: rtl/sm_divider.sv
// Sequential restoring divider, one quotient bit per clock, start/done flow shared with the multiplier.
// Optional macro SM_DIVIDER_EARLY_EXIT_EN: finish in LOAD when dividend < divisor.
module sm_divider #(
    parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  sm_divider_if.slave  io
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] d_reg, d_next;
  logic [WIDTH:0]   r_reg, r_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] quotient_reg, quotient_next;
  logic [WIDTH-1:0] remainder_reg, remainder_next;
  logic             dbz_reg, dbz_next;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             fits;
  logic [WIDTH-1:0] q_shifted;

  // Trial subtraction is done WIDTH+1 bits wide so the compare never overflows.
  assign trial     = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
  assign fits      = (trial >= {1'b0, d_reg});
  assign diff      = trial - {1'b0, d_reg};
  assign q_shifted = {q_reg[WIDTH-2:0], fits};

  always_comb begin
    state_next     = state_reg;
    q_next         = q_reg;
    d_next         = d_reg;
    r_next         = r_reg;
    count_next     = count_reg;
    quotient_next  = quotient_reg;
    remainder_next = remainder_reg;
    dbz_next       = dbz_reg;
    case (state_reg)
      IDLE: begin
        if (io.start) begin
          q_next     = io.dividend;
          d_next     = io.divisor;
          dbz_next   = 1'b0;
          state_next = LOAD;
        end
      end
      LOAD: begin
        r_next     = '0;
        count_next = '0;
        if (d_reg == '0) begin
          dbz_next       = 1'b1;
          quotient_next  = '1;
          remainder_next = q_reg;
          state_next     = DONE;
        end
`ifdef SM_DIVIDER_EARLY_EXIT_EN
        else if (q_reg < d_reg) begin
          quotient_next  = '0;
          remainder_next = q_reg;
          state_next     = DONE;
        end
`endif
        else begin
          state_next = ITER;
        end
      end
      ITER: begin
        r_next     = fits ? diff : trial;
        q_next     = q_shifted;
        count_next = count_reg + CW'(1);
        if (count_reg == CW'(WIDTH - 1)) begin
          quotient_next  = q_shifted;
          remainder_next = r_next[WIDTH-1:0];
          state_next     = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      q_reg         <= '0;
      d_reg         <= '0;
      r_reg         <= '0;
      count_reg     <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      q_reg         <= q_next;
      d_reg         <= d_next;
      r_reg         <= r_next;
      count_reg     <= count_next;
      quotient_reg  <= quotient_next;
      remainder_reg <= remainder_next;
      dbz_reg       <= dbz_next;
    end
  end

  assign io.quotient    = quotient_reg;
  assign io.remainder   = remainder_reg;
  assign io.div_by_zero = dbz_reg;
  assign io.done        = (state_reg == DONE);
  assign io.busy        = (state_reg == LOAD) || (state_reg == ITER);

endmodule
